// File: rtl/rv32_trap_pkg.sv
// rv32_trap_pkg: shared constants for the M-mode trap sequencer.
//   CSR addresses, trap cause codes, mstatus bit positions and the
//   sequencer state encoding.
package rv32_trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_M_EXT_IRQ  = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } trap_state_e;

endpackage

// File: rtl/trap_csr_regs.sv
// trap_csr_regs: storage for mstatus (MIE/MPIE), mtvec, mepc, mcause.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   csr_we_i/addr/wdata  : software write port (from WB)
//   csr_rdata_o          : combinational read of csr_addr_i
//   hw_trap_i / hw_mret_i: one-cycle commit strobes from the sequencer
//   hw_epc_i, hw_cause_i : values committed on hw_trap_i
//   mtvec_o, mepc_o, mie_o: current values used for redirect / irq gating
module trap_csr_regs
    import rv32_trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic            hw_trap_i,
    input  logic            hw_mret_i,
    input  logic [XLEN-1:0] hw_epc_i,
    input  logic [XLEN-1:0] hw_cause_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q;

    // Hardware commit owns mstatus (trap or mret) and mepc/mcause (trap);
    // a software write to any of those in the commit cycle is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= RESET_MTVEC & ALIGN_MASK;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            if (csr_we_i) begin
                unique case (csr_addr_i)
                    CSR_MSTATUS: if (!hw_trap_i && !hw_mret_i) begin
                        mie_q  <= csr_wdata_i[MSTATUS_MIE];
                        mpie_q <= csr_wdata_i[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:  mtvec_q <= csr_wdata_i & ALIGN_MASK;
                    CSR_MEPC:   if (!hw_trap_i) mepc_q <= csr_wdata_i & ALIGN_MASK;
                    CSR_MCAUSE: if (!hw_trap_i) mcause_q <= csr_wdata_i;
                    default: ;
                endcase
            end
            if (hw_trap_i) begin
                mepc_q   <= hw_epc_i & ALIGN_MASK;
                mcause_q <= hw_cause_i;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (hw_mret_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        unique case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[MSTATUS_MIE]  = mie_q;
                csr_rdata_o[MSTATUS_MPIE] = mpie_q;
                csr_rdata_o[12:11]        = 2'b11;  // MPP hardwired to M
            end
            CSR_MTVEC:  csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            default:    csr_rdata_o = '0;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: M-mode trap entry / mret sequencer for the RV32I pipe.
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid, id_pc          : live ID instruction and its PC
//   ecall, ebreak, mret      : decode strobes (mutually exclusive)
//   ext_irq                  : level external interrupt, gated by MIE
//   pipe_busy                : older instructions still in EX/MEM/WB
//   csr_we/addr/wdata/rdata  : software CSR port
//   stall, flush             : front-end hold / pipe kill
//   redirect_valid/pc        : fetch redirect, only in the commit cycle
//   mie_o                    : current mstatus.MIE
module trap_sequencer
    import rv32_trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            mret,
    input  logic            ext_irq,
    input  logic            pipe_busy,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie_o
);

    trap_state_e     state_q;
    logic            is_trap_q;
    logic [XLEN-1:0] cause_q, pc_q;

    logic            mie, evt, evt_trap, commit;
    logic [XLEN-1:0] cause_d, mtvec, mepc;

    // Event priority: enabled interrupt > ecall > ebreak > mret.
    always_comb begin
        evt_trap = 1'b1;
        cause_d  = '0;
        if (ext_irq && mie)  cause_d = XLEN'(CAUSE_M_EXT_IRQ);
        else if (ecall)      cause_d = XLEN'(CAUSE_ECALL_M);
        else if (ebreak)     cause_d = XLEN'(CAUSE_BREAKPOINT);
        else                 evt_trap = 1'b0;
    end

    assign evt = (state_q == ST_IDLE) && id_valid && (evt_trap || mret);

    // IDLE skips DRAIN when nothing is in flight, giving the one-cycle
    // best-case redirect; each busy cycle adds one cycle of DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            is_trap_q <= 1'b0;
            cause_q   <= '0;
            pc_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (evt) begin
                    is_trap_q <= evt_trap;
                    cause_q   <= cause_d;
                    pc_q      <= id_pc;
                    state_q   <= pipe_busy ? ST_DRAIN : ST_COMMIT;
                end
                ST_DRAIN:  if (!pipe_busy) state_q <= ST_COMMIT;
                ST_COMMIT: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign commit         = (state_q == ST_COMMIT);
    assign stall          = evt || (state_q != ST_IDLE);
    assign flush          = commit;
    assign redirect_valid = commit;
    assign redirect_pc    = commit ? (is_trap_q ? mtvec : mepc) : '0;
    assign mie_o          = mie;

    trap_csr_regs #(
        .XLEN        (XLEN),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr (
        .clk_i       (clk),
        .rst_i       (rst),
        .csr_we_i    (csr_we),
        .csr_addr_i  (csr_addr),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .hw_trap_i   (commit && is_trap_q),
        .hw_mret_i   (commit && !is_trap_q),
        .hw_epc_i    (pc_q),
        .hw_cause_i  (cause_q),
        .mtvec_o     (mtvec),
        .mepc_o      (mepc),
        .mie_o       (mie)
    );

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer.
module tb_trap_sequencer;

    localparam logic [31:0] RST_VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, ecall, ebreak, mret, ext_irq, pipe_busy, csr_we;
    logic [31:0] id_pc, csr_wdata, csr_rdata, redirect_pc;
    logic [11:0] csr_addr;
    logic        stall, flush, redirect_valid, mie_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(32), .RESET_MTVEC(RST_VEC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .ecall(ecall), .ebreak(ebreak), .mret(mret), .ext_irq(ext_irq),
        .pipe_busy(pipe_busy), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .stall(stall),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mie_o(mie_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        cyc();
        csr_we = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic ev(input logic [31:0] pc, input logic e, input logic b,
                      input logic m, input logic irq, input logic busy);
        id_valid = 1'b1; id_pc = pc; ecall = e; ebreak = b; mret = m;
        ext_irq = irq; pipe_busy = busy;
        #1;
    endtask

    task automatic clr();
        id_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; ext_irq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr(); pipe_busy = 1'b0; csr_we = 1'b0;
        csr_addr = '0; csr_wdata = '0; id_pc = '0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        // reset state
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_rv",    {31'b0, redirect_valid}, 32'd0);
        chk("rst_rpc",   redirect_pc, 32'd0);
        chk("rst_mie",   {31'b0, mie_o}, 32'd0);
        csr_chk("rst_mtvec",   12'h305, RST_VEC);
        csr_chk("rst_mstatus", 12'h300, 32'h1800);

        // CSR masking
        csr_wr(12'h305, 32'h203);
        csr_chk("mtvec_mask", 12'h305, 32'h200);
        csr_wr(12'h300, 32'hFFFF_FFFF);
        csr_chk("mstatus_mask", 12'h300, 32'h1888);
        chk("mie_set", {31'b0, mie_o}, 32'd1);
        csr_wr(12'h7C0, 32'hDEAD_BEEF);
        csr_chk("unmapped", 12'h7C0, 32'h0);

        // ecall, no drain
        ev(32'h100, 1, 0, 0, 0, 0);
        chk("ecall_stall_evt", {31'b0, stall}, 32'd1);
        chk("ecall_flush_evt", {31'b0, flush}, 32'd0);
        cyc(); clr(); #1;
        chk("ecall_flush",  {31'b0, flush}, 32'd1);
        chk("ecall_rv",     {31'b0, redirect_valid}, 32'd1);
        chk("ecall_rpc",    redirect_pc, 32'h200);
        chk("ecall_stall",  {31'b0, stall}, 32'd1);
        cyc();
        chk("ecall_idle_stall", {31'b0, stall}, 32'd0);
        chk("ecall_idle_rpc",   redirect_pc, 32'd0);
        csr_chk("ecall_mepc",    12'h341, 32'h100);
        csr_chk("ecall_mcause",  12'h342, 32'd11);
        csr_chk("ecall_mstatus", 12'h300, 32'h1880);

        // mret
        ev(32'h200, 0, 0, 1, 0, 0);
        chk("mret_stall_evt", {31'b0, stall}, 32'd1);
        cyc(); clr(); #1;
        chk("mret_rv",  {31'b0, redirect_valid}, 32'd1);
        chk("mret_rpc", redirect_pc, 32'h100);
        cyc();
        csr_chk("mret_mstatus", 12'h300, 32'h1888);
        chk("mret_mie", {31'b0, mie_o}, 32'd1);

        // drain: busy for event cycle + two DRAIN cycles, then quiet
        ev(32'h124, 0, 1, 0, 0, 1);
        chk("drn_stall0", {31'b0, stall}, 32'd1);
        cyc(); clr(); #1;
        chk("drn_stall1", {31'b0, stall}, 32'd1);
        chk("drn_flush1", {31'b0, flush}, 32'd0);
        cyc();
        ev(32'h128, 0, 0, 1, 0, 1);  // mret during DRAIN must be ignored
        chk("drn_stall2", {31'b0, stall}, 32'd1);
        chk("drn_flush2", {31'b0, flush}, 32'd0);
        cyc(); clr(); pipe_busy = 1'b0; #1;
        chk("drn_stall3", {31'b0, stall}, 32'd1);
        chk("drn_flush3", {31'b0, flush}, 32'd0);
        cyc();
        chk("drn_stall4", {31'b0, stall}, 32'd1);
        chk("drn_rv4",    {31'b0, redirect_valid}, 32'd1);
        chk("drn_rpc4",   redirect_pc, 32'h200);
        cyc();
        chk("drn_stall5", {31'b0, stall}, 32'd0);
        csr_chk("drn_mcause", 12'h342, 32'd3);
        csr_chk("drn_mepc",   12'h341, 32'h124);

        // priority, MIE=1; software mcause write in COMMIT loses
        csr_wr(12'h300, 32'h8);
        ev(32'h302, 0, 1, 0, 1, 0);
        cyc(); clr(); csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h55; #1;
        chk("pri_rpc", redirect_pc, 32'h200);
        cyc(); csr_we = 1'b0;
        csr_chk("pri_mcause",  12'h342, 32'h8000_000B);
        csr_chk("pri_mepc",    12'h341, 32'h300);
        csr_chk("pri_mstatus", 12'h300, 32'h1880);

        // priority, MIE=0
        ev(32'h400, 0, 1, 0, 1, 0);
        cyc(); clr(); cyc();
        csr_chk("pri0_mcause", 12'h342, 32'd3);
        csr_chk("pri0_mepc",   12'h341, 32'h400);

        // masked interrupt alone: no action
        ev(32'h500, 0, 0, 0, 1, 0);
        chk("mask_stall", {31'b0, stall}, 32'd0);
        cyc(); clr(); #1;
        chk("mask_flush", {31'b0, flush}, 32'd0);

        // reset in DRAIN
        ev(32'h600, 1, 0, 0, 0, 1);
        cyc(); clr(); #1;
        chk("rstd_stall_pre", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        cyc(); rst = 1'b0; pipe_busy = 1'b0; #1;
        chk("rstd_stall", {31'b0, stall}, 32'd0);
        chk("rstd_rv",    {31'b0, redirect_valid}, 32'd0);
        csr_chk("rstd_mepc",  12'h341, 32'h0);
        csr_chk("rstd_mtvec", 12'h305, RST_VEC);
        cyc();
        chk("rstd_noflush", {31'b0, flush}, 32'd0);
        // FSM accepts a fresh event straight away
        ev(32'h700, 1, 0, 0, 0, 0);
        cyc(); clr(); #1;
        chk("rstd_rpc", redirect_pc, RST_VEC);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
